// File: rtl/core_pkg.sv
// Shared core types for the memory hazard controller: stall FSM state encoding
// and the default register-index width.
package core_pkg;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ARB  = 3'd1,
        RD_WAIT = 3'd2,
        WR_ARB  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;
endpackage

// File: rtl/mem_hazard_ctrl_if.sv
// Data-memory handshake bundle between the stall controller (master) and the
// data memory (slave).
interface mem_hazard_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;
    logic mem_err;

    modport master (output mem_req, output mem_we, output mem_err, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_err, output mem_ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a clear input
// that takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rstN)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + ONE;
    end
endmodule

// File: rtl/mem_hazard_ctrl.sv
// Pipeline stall controller: holds PC, IF/ID and ID/EX while a data-memory access
// runs (IDLE -> x_ARB -> x_WAIT -> IDLE), with access timeout and load-use bubble.
module mem_hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FWD_LOAD       = 1,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic [REG_ADDR_W-1:0] ID_Ex_rd,
    input  logic                  ID_Ex_MemRead,
    input  logic                  ID_Ex_MemWrite,
    input  logic                  cnt_clr,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  ID_Ex_enable,
    output logic                  ID_Ex_flush,
    output logic [CNT_W-1:0]      stall_cnt,
    mem_hazard_ctrl_if.master     mem
);
    localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   T_ONE  = TW'(1);

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tcnt;
    logic            stall;
    logic            rel;
    logic            abort;
    logic            load_use;
    logic            err_q;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= abort;
        end
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        rel         = 1'b0;
        abort       = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        case (state)
            IDLE: begin
                if (ID_Ex_MemRead) begin
                    stall     = 1'b1;
                    state_nxt = RD_ARB;
                end else if (ID_Ex_MemWrite) begin
                    stall     = 1'b1;
                    state_nxt = WR_ARB;
                end
            end
            RD_ARB, WR_ARB: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = (state == WR_ARB);
                stall       = 1'b1;
                if (!mem.mem_ready)
                    state_nxt = (state == RD_ARB) ? RD_WAIT : WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                mem.mem_we = (state == WR_WAIT);
                if (mem.mem_ready) begin
                    rel       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort releases the pipeline like a normal completion, minus the bubble.
        if ((state != IDLE) && !rel && (tcnt == T_LAST)) begin
            abort     = 1'b1;
            stall     = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN)
            tcnt <= '0;
        else if (state == IDLE)
            tcnt <= '0;
        else
            tcnt <= tcnt + T_ONE;
    end

    assign load_use = (FWD_LOAD == 0) && rel && (state == RD_WAIT) &&
                      (ID_Ex_rd != '0) &&
                      ((ID_Ex_rd == IF_ID_rs1) || (ID_Ex_rd == IF_ID_rs2));

    assign PC_write     = ~stall & ~load_use;
    assign IF_ID_write  = ~stall & ~load_use;
    assign ID_Ex_enable = ~stall;
    assign ID_Ex_flush  = load_use;
    assign mem.mem_err  = err_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rstN (rstN),
        .inc  (~PC_write),
        .clr  (cnt_clr),
        .cnt  (stall_cnt)
    );
endmodule

// File: tb/tb_mem_hazard_ctrl.sv
// Directed bench: dut_a (no load forwarding, 8-cycle timeout, 4-bit counter) and
// dut_f (forwarding, defaults) share the same pipeline/memory stimulus.
module tb_mem_hazard_ctrl;
    logic       clk;
    logic       rstN;
    logic [4:0] rs1, rs2, rd;
    logic       mem_read, mem_write, cnt_clr, ready;

    logic        pcw_a, ifw_a, en_a, fl_a;
    logic [3:0]  cnt_a;
    logic        pcw_f, ifw_f, en_f, fl_f;
    logic [31:0] cnt_f;

    int vecs = 0;
    int errs = 0;

    mem_hazard_ctrl_if bus_a ();
    mem_hazard_ctrl_if bus_f ();
    assign bus_a.mem_ready = ready;
    assign bus_f.mem_ready = ready;

    mem_hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT_CYCLES(8), .FWD_LOAD(0), .CNT_W(4)) dut_a (
        .clk(clk), .rstN(rstN), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_Ex_rd(rd),
        .ID_Ex_MemRead(mem_read), .ID_Ex_MemWrite(mem_write), .cnt_clr(cnt_clr),
        .PC_write(pcw_a), .IF_ID_write(ifw_a), .ID_Ex_enable(en_a), .ID_Ex_flush(fl_a),
        .stall_cnt(cnt_a), .mem(bus_a)
    );

    mem_hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT_CYCLES(255), .FWD_LOAD(1), .CNT_W(32)) dut_f (
        .clk(clk), .rstN(rstN), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_Ex_rd(rd),
        .ID_Ex_MemRead(mem_read), .ID_Ex_MemWrite(mem_write), .cnt_clr(cnt_clr),
        .PC_write(pcw_f), .IF_ID_write(ifw_f), .ID_Ex_enable(en_f), .ID_Ex_flush(fl_f),
        .stall_cnt(cnt_f), .mem(bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mem_read = 1'b0; mem_write = 1'b0; cnt_clr = 1'b0; ready = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        idle_inputs();
        tick(); tick();
        #1;
        vecs++; if (bus_a.mem_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b exp=0", bus_a.mem_req); end
        vecs++; if (bus_a.mem_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", bus_a.mem_err); end
        vecs++; if (cnt_a !== 4'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
        vecs++; if (pcw_a !== 1'b1) begin errs++; $display("FAIL reset_pcw got=%b exp=1", pcw_a); end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_read;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        mem_read = 1'b1; ready = 1'b1; #1;
        vecs++; if (pcw_a !== 1'b0) begin errs++; $display("FAIL read_c0_pcw got=%b exp=0", pcw_a); end
        vecs++; if (bus_a.mem_req !== 1'b0) begin errs++; $display("FAIL read_c0_req got=%b exp=0", bus_a.mem_req); end
        tick();
        ready = 1'b0; #1;
        vecs++; if (bus_a.mem_req !== 1'b1) begin errs++; $display("FAIL read_c1_req got=%b exp=1", bus_a.mem_req); end
        vecs++; if (bus_a.mem_we !== 1'b0) begin errs++; $display("FAIL read_c1_we got=%b exp=0", bus_a.mem_we); end
        vecs++; if (pcw_a !== 1'b0) begin errs++; $display("FAIL read_c1_pcw got=%b exp=0", pcw_a); end
        tick();
        for (int c = 2; c < 4; c++) begin
            #1;
            vecs++; if (bus_a.mem_req !== 1'b0) begin errs++; $display("FAIL read_wait_req c=%0d got=%b exp=0", c, bus_a.mem_req); end
            vecs++; if (pcw_a !== 1'b0) begin errs++; $display("FAIL read_wait_pcw c=%0d got=%b exp=0", c, pcw_a); end
            tick();
        end
        ready = 1'b1; #1;
        vecs++; if ({pcw_a, ifw_a, en_a, fl_a} !== 4'b1110) begin errs++; $display("FAIL read_rel_en got=%b exp=1110", {pcw_a, ifw_a, en_a, fl_a}); end
        vecs++; if (pcw_f !== 1'b1) begin errs++; $display("FAIL read_rel_pcw_f got=%b exp=1", pcw_f); end
        tick();
        mem_read = 1'b0; #1;
        vecs++; if (cnt_a !== 4'd4) begin errs++; $display("FAIL read_cnt_a got=%0d exp=4", cnt_a); end
        vecs++; if (cnt_f !== 32'd4) begin errs++; $display("FAIL read_cnt_f got=%0d exp=4", cnt_f); end
        vecs++; if (pcw_a !== 1'b1) begin errs++; $display("FAIL read_after_pcw got=%b exp=1", pcw_a); end
    endtask

    task automatic test_both_ops;
        mem_read = 1'b1; mem_write = 1'b1; ready = 1'b1; #1;
        vecs++; if (pcw_a !== 1'b0) begin errs++; $display("FAIL both_c0_pcw got=%b exp=0", pcw_a); end
        tick();
        ready = 1'b0; #1;
        vecs++; if ({bus_a.mem_req, bus_a.mem_we} !== 2'b10) begin errs++; $display("FAIL both_c1_req_we got=%b exp=10", {bus_a.mem_req, bus_a.mem_we}); end
        tick();
        ready = 1'b1; #1;
        vecs++; if ({bus_a.mem_we, pcw_a} !== 2'b01) begin errs++; $display("FAIL both_rel_we_pcw got=%b exp=01", {bus_a.mem_we, pcw_a}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_write;
        mem_write = 1'b1; ready = 1'b1; #1;
        vecs++; if ({bus_a.mem_we, pcw_a} !== 2'b00) begin errs++; $display("FAIL wr_c0_we_pcw got=%b exp=00", {bus_a.mem_we, pcw_a}); end
        tick();
        ready = 1'b0; #1;
        vecs++; if ({bus_a.mem_req, bus_a.mem_we} !== 2'b11) begin errs++; $display("FAIL wr_arb_req_we got=%b exp=11", {bus_a.mem_req, bus_a.mem_we}); end
        tick();
        #1;
        vecs++; if ({bus_a.mem_req, bus_a.mem_we, pcw_a} !== 3'b010) begin errs++; $display("FAIL wr_wait got=%b exp=010", {bus_a.mem_req, bus_a.mem_we, pcw_a}); end
        tick();
        ready = 1'b1; #1;
        vecs++; if ({bus_a.mem_we, pcw_a} !== 2'b11) begin errs++; $display("FAIL wr_rel_we_pcw got=%b exp=11", {bus_a.mem_we, pcw_a}); end
        tick();
        mem_write = 1'b0; #1;
        vecs++; if (bus_a.mem_we !== 1'b0) begin errs++; $display("FAIL wr_after_we got=%b exp=0", bus_a.mem_we); end
    endtask

    task automatic test_back_to_back;
        mem_write = 1'b1; ready = 1'b1; tick();
        ready = 1'b0; tick();
        ready = 1'b1; #1;
        vecs++; if (pcw_a !== 1'b1) begin errs++; $display("FAIL b2b_rel_pcw got=%b exp=1", pcw_a); end
        tick();
        mem_write = 1'b0; mem_read = 1'b1; #1;
        vecs++; if (pcw_a !== 1'b0) begin errs++; $display("FAIL b2b_idle_pcw got=%b exp=0", pcw_a); end
        tick();
        ready = 1'b0; #1;
        vecs++; if ({bus_a.mem_req, bus_a.mem_we} !== 2'b10) begin errs++; $display("FAIL b2b_arb got=%b exp=10", {bus_a.mem_req, bus_a.mem_we}); end
        tick();
        ready = 1'b1; #1;
        vecs++; if (pcw_a !== 1'b1) begin errs++; $display("FAIL b2b_rel2_pcw got=%b exp=1", pcw_a); end
        tick();
        idle_inputs();
    endtask

    task automatic test_load_use;
        mem_read = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; ready = 1'b1; tick();
        ready = 1'b0; tick();
        ready = 1'b1; #1;
        vecs++; if ({pcw_a, ifw_a, en_a, fl_a} !== 4'b0011) begin errs++; $display("FAIL lu_bubble got=%b exp=0011", {pcw_a, ifw_a, en_a, fl_a}); end
        vecs++; if ({pcw_f, ifw_f, en_f, fl_f} !== 4'b1110) begin errs++; $display("FAIL lu_fwd got=%b exp=1110", {pcw_f, ifw_f, en_f, fl_f}); end
        tick();
        mem_read = 1'b0; rd = 5'd0; #1;
        vecs++; if ({pcw_a, fl_a} !== 2'b10) begin errs++; $display("FAIL lu_after got=%b exp=10", {pcw_a, fl_a}); end
        tick();
        mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; tick();
        ready = 1'b0; tick();
        ready = 1'b1; #1;
        vecs++; if ({pcw_a, ifw_a, fl_a} !== 3'b110) begin errs++; $display("FAIL lu_rd0 got=%b exp=110", {pcw_a, ifw_a, fl_a}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        mem_read = 1'b1; ready = 1'b1; rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5; #1;
        vecs++; if (pcw_a !== 1'b0) begin errs++; $display("FAIL to_c0_pcw got=%b exp=0", pcw_a); end
        tick();
        for (int c = 1; c < 8; c++) begin
            #1;
            vecs++; if ({bus_a.mem_req, pcw_a, bus_a.mem_err} !== 3'b100) begin errs++; $display("FAIL to_arb c=%0d got=%b exp=100", c, {bus_a.mem_req, pcw_a, bus_a.mem_err}); end
            tick();
        end
        #1;
        vecs++; if ({pcw_a, fl_a, bus_a.mem_err} !== 3'b100) begin errs++; $display("FAIL to_abort got=%b exp=100", {pcw_a, fl_a, bus_a.mem_err}); end
        tick();
        mem_read = 1'b0; ready = 1'b0; #1;
        vecs++; if (bus_a.mem_err !== 1'b1) begin errs++; $display("FAIL to_err_pulse got=%b exp=1", bus_a.mem_err); end
        vecs++; if ({bus_a.mem_req, pcw_a} !== 2'b01) begin errs++; $display("FAIL to_idle got=%b exp=01", {bus_a.mem_req, pcw_a}); end
        vecs++; if (cnt_a !== 4'd8) begin errs++; $display("FAIL to_cnt got=%0d exp=8", cnt_a); end
        vecs++; if (bus_f.mem_err !== 1'b0) begin errs++; $display("FAIL to_err_f got=%b exp=0", bus_f.mem_err); end
        tick();
        ready = 1'b1; #1;
        vecs++; if (bus_a.mem_err !== 1'b0) begin errs++; $display("FAIL to_err_end got=%b exp=0", bus_a.mem_err); end
        vecs++; if (pcw_f !== 1'b1) begin errs++; $display("FAIL to_f_rel got=%b exp=1", pcw_f); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        mem_write = 1'b1; ready = 1'b1; tick();
        ready = 1'b0; tick();
        #1;
        vecs++; if ({bus_a.mem_req, bus_a.mem_we} !== 2'b01) begin errs++; $display("FAIL rm_wait got=%b exp=01", {bus_a.mem_req, bus_a.mem_we}); end
        rstN = 1'b0;
        tick();
        rstN = 1'b1; mem_write = 1'b0; ready = 1'b1; #1;
        vecs++; if ({bus_a.mem_req, bus_a.mem_we, bus_a.mem_err} !== 3'b000) begin errs++; $display("FAIL rm_outs got=%b exp=000", {bus_a.mem_req, bus_a.mem_we, bus_a.mem_err}); end
        vecs++; if (cnt_a !== 4'd0) begin errs++; $display("FAIL rm_cnt_a got=%0d exp=0", cnt_a); end
        vecs++; if (cnt_f !== 32'd0) begin errs++; $display("FAIL rm_cnt_f got=%0d exp=0", cnt_f); end
        vecs++; if (pcw_a !== 1'b1) begin errs++; $display("FAIL rm_pcw got=%b exp=1", pcw_a); end
        tick();
    endtask

    task automatic test_saturation;
        idle_inputs();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        mem_read = 1'b1; ready = 1'b1;
        repeat (27) tick();
        #1;
        vecs++; if (cnt_a !== 4'd15) begin errs++; $display("FAIL sat_cnt_a got=%0d exp=15", cnt_a); end
        vecs++; if (cnt_f !== 32'd27) begin errs++; $display("FAIL sat_cnt_f got=%0d exp=27", cnt_f); end
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0; #1;
        vecs++; if (cnt_a !== 4'd0) begin errs++; $display("FAIL clr_cnt_a got=%0d exp=0", cnt_a); end
        vecs++; if (cnt_f !== 32'd0) begin errs++; $display("FAIL clr_cnt_f got=%0d exp=0", cnt_f); end
        tick(); #1;
        vecs++; if (cnt_a !== 4'd1) begin errs++; $display("FAIL post_clr_cnt_a got=%0d exp=1", cnt_a); end
        vecs++; if (cnt_f !== 32'd1) begin errs++; $display("FAIL post_clr_cnt_f got=%0d exp=1", cnt_f); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read();
        test_both_ops();
        test_write();
        test_back_to_back();
        test_load_use();
        test_timeout();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_hazard_ctrl.md
# mem_hazard_ctrl

Parametrised pipeline stall controller for the 5-stage core: freezes PC, IF/ID and ID/EX while the data memory completes a multi-cycle read or write. Extends the fixed memory stall FSM with a request/handshake output, per-access timeout with error reporting, an optional load-use bubble for builds without load forwarding, and a saturating stall-cycle performance counter. Sits between the decode/execute pipeline registers and the data-memory interface.

## Interface
- REG_ADDR_W, 5, register-index width.
- TIMEOUT_CYCLES, 255, maximum cycles per access (ARB+WAIT) before abort; must be ≥ 2.
- FWD_LOAD, 1, 1 = load result forwarded, no bubble; 0 = insert one load-use bubble.
- CNT_W, 32, stall counter width.
- clk  input  1  clock, rising edge.
- rstN  input  1  reset, synchronous, active-low.
- IF_ID_rs1, IF_ID_rs2  input  REG_ADDR_W  source registers of the instruction in IF/ID.
- ID_Ex_rd  input  REG_ADDR_W  destination of the instruction in ID/EX.
- ID_Ex_MemRead, ID_Ex_MemWrite  input  1  memory op in ID/EX.
- mem_ready  input  1  memory ready; drops low to accept, returns high on completion.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- PC_write, IF_ID_write, ID_Ex_enable  output  1  pipeline register enables.
- ID_Ex_flush  output  1  load bubble into ID/EX at the next edge.
- mem_req, mem_we  output  1  access request / write qualifier.
- mem_err  output  1  one-cycle pulse on timeout abort.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

## Operation
- States: IDLE, RD_ARB, RD_WAIT, WR_ARB, WR_WAIT.
- IDLE: MemRead → RD_ARB; else MemWrite → WR_ARB. Both high: read wins; write not performed.
- x_ARB: mem_req=1; mem_ready==0 → x_WAIT.
- x_WAIT: mem_req=0; mem_ready==1 → IDLE (release cycle).
- mem_we=1 in WR_ARB and WR_WAIT only.
- stall = (IDLE & (MemRead|MemWrite)) | x_ARB | (x_WAIT & ~mem_ready), with abort overriding (see below).
- PC_write = IF_ID_write = ID_Ex_enable = ~stall, except during a load-use release.
- Release cycle (x_WAIT & mem_ready): stall=0, so the memory instruction leaves ID/EX at that edge. It does not restart in IDLE.
- Load-use (FWD_LOAD=0 only): release from RD_WAIT with ID_Ex_rd≠0 and ID_Ex_rd ∈ {IF_ID_rs1, IF_ID_rs2}.
  - PC_write=0, IF_ID_write=0, ID_Ex_enable=1, ID_Ex_flush=1 for that single cycle.
  - With FWD_LOAD=1, ID_Ex_flush is constant 0.
- Timeout:
  - tcnt, width $clog2(TIMEOUT_CYCLES+1), is cleared on IDLE→x_ARB and increments every cycle in x_ARB/x_WAIT.
  - When tcnt==TIMEOUT_CYCLES-1 without a transition to IDLE, next state is IDLE and mem_err pulses the following cycle.
  - The abort cycle is treated as a release: stall=0, no load-use bubble.
- stall_cnt increments on every cycle with PC_write==0 and saturates at all-ones.
  - cnt_clr has priority over increment; a cleared cycle counts 0.

## Timing
- Reset (rstN=0 at edge): state=IDLE, tcnt=0, mem_err=0, stall_cnt=0.
- Enables, flush, mem_req and mem_we are combinational from state and inputs; there is no extra latency.
- Minimum read: IDLE(stall) → RD_ARB(mem_ready drops) → RD_WAIT(mem_ready high, release) gives 2 stalled cycles plus the release cycle.
- mem_err is registered: it is high exactly one cycle, the cycle after the abort cycle.
- Reset mid-access: the FSM returns to IDLE and mem_req drops the cycle after the reset edge. No mem_err is issued.
- A memory op arriving in IDLE in the cycle right after a release starts a new access immediately (back-to-back).

## Structure
- Shared package core_pkg: state_t enum (3-bit, encodings IDLE=0, RD_ARB=1, RD_WAIT=2, WR_ARB=3, WR_WAIT=4) and a REG_ADDR_W default constant.
- Sub-module sat_counter (width, inc, clr, cnt) instantiated for stall_cnt.
- One FSM always_ff, one next-state/output always_comb, and a separate timeout counter.

## Test plan
- Read, memory drops ready at cycle 1 and raises at cycle 4 → PC_write low cycles 0–3, high at 4; mem_req high only in RD_ARB; stall_cnt=4.
- Write with MemRead=MemWrite=1 → read path taken, mem_we never high. Write-only → mem_we high through WR_ARB/WR_WAIT.
- FWD_LOAD=0, load rd=5, IF_ID_rs2=5 → at release PC_write=0, IF_ID_write=0, ID_Ex_flush=1 for one cycle. With rd=0 → no flush.
- TIMEOUT_CYCLES=8, mem_ready held high forever → abort after 8 stalled cycles in RD_ARB, mem_err pulse next cycle, FSM back in IDLE.
- rstN low for one edge while in WR_WAIT → IDLE next cycle, mem_req=0, mem_err=0, stall_cnt=0.
- CNT_W=4, 20 stalled cycles → stall_cnt saturates at 15. cnt_clr together with a stall → 0.
